change_dispenser: RTL and testbench
===================================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter PULSE_LEN, default 25: cycles the eject solenoid is driven per coin.
REQ-002 Parameter GAP_LEN, default 25: idle cycles between consecutive coins.
REQ-003 Parameter TIMEOUT, default 100: maximum cycles from eject rise to coin_sense rise before a jam fault.
REQ-004 clk  input  1  sole clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to dispense `amount` quarters.
REQ-007 amount  input  8  quarters to return, unsigned; sampled only on an accepted start.
REQ-008 coin_sense  input  1  coin-passed optical sensor, synchronous to clk, high while a coin is in the chute.
REQ-009 clear_fault  input  1  one-cycle fault acknowledge.
REQ-010 eject  output  1  solenoid drive; one pulse per quarter.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse when the requested amount has been fully dispensed.
REQ-013 fault  output  1  sticky jam indication.
REQ-014 dispensed  output  8  quarters confirmed by coin_sense since the last accepted start.

Function
REQ-015 The state machine SHALL have the states IDLE, PULSE, WAIT_SENSE, GAP, FIN and FAULT.
REQ-016 In IDLE, start SHALL be accepted, latching amount into remaining and clearing dispensed; start outside IDLE SHALL be ignored.
REQ-017 An accepted start with amount=0 SHALL go to FIN, with done high on the next cycle and eject never asserted.
REQ-018 An accepted start with amount>0 SHALL enter PULSE, with eject high from the next cycle for exactly PULSE_LEN cycles, then enter WAIT_SENSE.
REQ-019 Sense edge: a coin_sense 0->1 transition (one registered stage) SHALL count only in PULSE or WAIT_SENSE, and at most once per coin.
REQ-020 On a counted edge, dispensed SHALL increment and remaining SHALL decrement (no wrap; both saturate at 255/0).
REQ-021 An edge counted during PULSE SHALL NOT truncate the pulse; the FSM SHALL move to GAP or FIN when the pulse ends.
REQ-022 Leaving WAIT_SENSE after a counted edge, the FSM SHALL go to FIN when remaining=0, else to GAP for GAP_LEN cycles and then to PULSE.
REQ-023 The jam timer SHALL start at eject rise; if TIMEOUT cycles elapse with no counted edge, the FSM SHALL enter FAULT.
REQ-024 In FAULT, fault SHALL be 1, eject SHALL be 0 and done SHALL NOT pulse; clear_fault SHALL return the FSM to IDLE and clear fault; start SHALL be ignored.
REQ-025 FIN SHALL last one cycle, with done=1, then return to IDLE.
REQ-026 dispensed SHALL hold its value in IDLE until the next accepted start.
REQ-027 A second coin_sense edge before the next PULSE SHALL be ignored and SHALL NOT be counted.
REQ-028 start and clear_fault in the same cycle SHALL be handled by the current state only; no input SHALL be queued.

Reset
REQ-029 On rst=1 at a clock edge, the FSM SHALL enter IDLE, and eject, busy, done, fault, dispensed, remaining and all timers SHALL be 0.
REQ-030 Reset SHALL take priority over every input, including mid-pulse, where eject SHALL drop on the same edge.

Structure
REQ-031 The state enumeration and the default PULSE_LEN, GAP_LEN and TIMEOUT values SHALL live in shared package vend_pkg, also used by the vending FSM.
REQ-032 One sub-module, dispense_timer, SHALL be used: a loadable down-counter with a zero flag, instantiated twice (pulse/gap timer and jam timer).
REQ-033 All state SHALL be synchronous to clk; there SHALL be no derived clocks.

Verification (bench parameters PULSE_LEN=4, GAP_LEN=2, TIMEOUT=10)
REQ-034 start with amount=3, and coin_sense pulsed 2 cycles after each eject fall -> 3 eject pulses of 4 cycles, gaps of 2 cycles or more, done once, dispensed=3.
REQ-035 start with amount=0 -> done 1 cycle after start, eject never high, dispensed=0.
REQ-036 start with amount=2, and no coin_sense after the 2nd eject -> fault rises 10 cycles after the 2nd eject rise, dispensed=1, no done; clear_fault -> IDLE, busy=0.
REQ-037 start with amount=1, and coin_sense rising during the pulse plus a second bounce edge -> dispensed=1, done pulses, extra edge ignored.
REQ-038 rst asserted on the 2nd cycle of the eject pulse -> eject=0 and all outputs 0 on that edge; a later start with amount=1 completes normally.
REQ-039 A second start while busy, with a different amount -> ignored; the original amount completes.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller and the change dispenser:
// state encoding, default timing and saturating counter helpers.
package vend_pkg;

  localparam int PULSE_LEN_DEF = 25;
  localparam int GAP_LEN_DEF   = 25;
  localparam int TIMEOUT_DEF   = 100;
  localparam int TMR_W         = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_PULSE      = 3'd1;
  localparam state_t ST_WAIT_SENSE = 3'd2;
  localparam state_t ST_GAP        = 3'd3;
  localparam state_t ST_FIN        = 3'd4;
  localparam state_t ST_FAULT      = 3'd5;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [7:0] sat_dec8(input logic [7:0] v);
    return (v == 8'h00) ? v : v - 8'd1;
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Request/status bundle between a vending controller (master) and the
// change dispenser (slave), including the coin chute sensor.
interface change_dispenser_if;
  logic       start;
  logic [7:0] amount;
  logic       coin_sense;
  logic       clear_fault;
  logic       eject;
  logic       busy;
  logic       done;
  logic       fault;
  logic [7:0] dispensed;

  modport master (
    output start, amount, coin_sense, clear_fault,
    input  eject, busy, done, fault, dispensed
  );

  modport slave (
    input  start, amount, coin_sense, clear_fault,
    output eject, busy, done, fault, dispensed
  );
endinterface

// File: rtl/dispense_timer.sv
// Loadable down-counter that stops at zero; o_zero flags the terminal count.
module dispense_timer
  import vend_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)                       r_cnt <= '0;
    else if (i_load)               r_cnt <= i_load_val;
    else if (i_en && r_cnt != '0)  r_cnt <= r_cnt - W'(1);
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/change_dispenser.sv
// Quarter dispenser: pulses the eject solenoid once per coin, confirms each
// coin on the chute sensor and faults if a coin fails to appear in time.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int PULSE_LEN = PULSE_LEN_DEF,
  parameter int GAP_LEN   = GAP_LEN_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  change_dispenser_if.slave bus
);

  state_t           r_state, w_next;
  logic [7:0]       r_remaining, r_dispensed, w_rem_after;
  logic             r_sense_d, r_counted;
  logic             w_edge, w_count, w_coin_seen;
  logic             w_pg_load, w_jam_load, w_pg_zero, w_jam_zero;
  logic [TMR_W-1:0] w_pg_val;

  // One coin per pulse: a rising sensor edge counts only while ejecting or waiting.
  assign w_edge      = bus.coin_sense & ~r_sense_d;
  assign w_count     = w_edge & ~r_counted &
                       ((r_state == ST_PULSE) || (r_state == ST_WAIT_SENSE));
  assign w_coin_seen = r_counted | w_count;
  assign w_rem_after = w_count ? sat_dec8(r_remaining) : r_remaining;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:
        if (bus.start) w_next = (bus.amount == 8'd0) ? ST_FIN : ST_PULSE;
      ST_PULSE:
        if (w_pg_zero) begin
          if (w_coin_seen)     w_next = (w_rem_after == 8'd0) ? ST_FIN : ST_GAP;
          else if (w_jam_zero) w_next = ST_FAULT;
          else                 w_next = ST_WAIT_SENSE;
        end else if (!w_coin_seen && w_jam_zero) begin
          w_next = ST_FAULT;
        end
      ST_WAIT_SENSE:
        if (w_count)         w_next = (w_rem_after == 8'd0) ? ST_FIN : ST_GAP;
        else if (w_jam_zero) w_next = ST_FAULT;
      ST_GAP:
        if (w_pg_zero) w_next = ST_PULSE;
      ST_FIN:
        w_next = ST_IDLE;
      ST_FAULT:
        if (bus.clear_fault) w_next = ST_IDLE;
      default:
        w_next = ST_IDLE;
    endcase
  end

  // Timers are armed on entry into a timed state; the jam timer spans pulse and wait.
  assign w_pg_load  = (w_next != r_state) && ((w_next == ST_PULSE) || (w_next == ST_GAP));
  assign w_pg_val   = (w_next == ST_PULSE) ? TMR_W'(PULSE_LEN - 1) : TMR_W'(GAP_LEN - 1);
  assign w_jam_load = (w_next == ST_PULSE) && (r_state != ST_PULSE);

  dispense_timer #(.W(TMR_W)) u_pg_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_pg_load),
    .i_en       ((r_state == ST_PULSE) || (r_state == ST_GAP)),
    .i_load_val (w_pg_val),
    .o_zero     (w_pg_zero)
  );

  dispense_timer #(.W(TMR_W)) u_jam_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_jam_load),
    .i_en       ((r_state == ST_PULSE) || (r_state == ST_WAIT_SENSE)),
    .i_load_val (TMR_W'(TIMEOUT - 1)),
    .o_zero     (w_jam_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_remaining <= 8'd0;
      r_dispensed <= 8'd0;
      r_sense_d   <= 1'b0;
      r_counted   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_sense_d <= bus.coin_sense;
      if (r_state == ST_IDLE && bus.start) begin
        r_remaining <= bus.amount;
        r_dispensed <= 8'd0;
      end else if (w_count) begin
        r_remaining <= sat_dec8(r_remaining);
        r_dispensed <= sat_inc8(r_dispensed);
      end
      if (w_jam_load)   r_counted <= 1'b0;
      else if (w_count) r_counted <= 1'b1;
    end
  end

  assign bus.eject     = (r_state == ST_PULSE);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.done      = (r_state == ST_FIN);
  assign bus.fault     = (r_state == ST_FAULT);
  assign bus.dispensed = r_dispensed;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a phase/elapsed-time model of the dispenser behaviour.
module tb_change_dispenser;

  localparam int PL = 4;
  localparam int GL = 2;
  localparam int TO = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   chk_en = 1'b0;

  change_dispenser_if bus();

  change_dispenser #(.PULSE_LEN(PL), .GAP_LEN(GL), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase plus elapsed-cycle counters, stepped on each rising edge.
  typedef enum {M_IDLE, M_EJECT, M_WAIT, M_GAP, M_FIN, M_JAM} mphase_e;
  mphase_e m_phase = M_IDLE;
  int m_elapsed = 0, m_since = 0, m_left = 0, m_disp = 0;
  bit m_got = 0, m_prev = 0;

  always @(posedge clk) begin : model
    bit rise, cnt;
    if (rst) begin
      m_phase = M_IDLE; m_left = 0; m_disp = 0; m_prev = 0; m_got = 0;
      m_elapsed = 0; m_since = 0;
    end else begin
      rise   = bus.coin_sense && !m_prev;
      m_prev = bus.coin_sense;
      cnt    = rise && !m_got && (m_phase == M_EJECT || m_phase == M_WAIT);
      if (cnt) begin
        if (m_disp < 255) m_disp++;
        if (m_left > 0)   m_left--;
        m_got = 1;
      end
      case (m_phase)
        M_IDLE: if (bus.start) begin
          m_left = int'(bus.amount); m_disp = 0;
          if (bus.amount == 0) m_phase = M_FIN;
          else begin m_phase = M_EJECT; m_elapsed = 0; m_since = 0; m_got = 0; end
        end
        M_EJECT: begin
          m_elapsed++; m_since++;
          if (m_elapsed == PL) begin
            if (m_got) begin
              if (m_left == 0) m_phase = M_FIN;
              else begin m_phase = M_GAP; m_elapsed = 0; end
            end else if (m_since >= TO) m_phase = M_JAM;
            else m_phase = M_WAIT;
          end else if (!m_got && m_since >= TO) m_phase = M_JAM;
        end
        M_WAIT: begin
          m_since++;
          if (cnt) begin
            if (m_left == 0) m_phase = M_FIN;
            else begin m_phase = M_GAP; m_elapsed = 0; end
          end else if (m_since >= TO) m_phase = M_JAM;
        end
        M_GAP: begin
          m_elapsed++;
          if (m_elapsed >= GL) begin
            m_phase = M_EJECT; m_elapsed = 0; m_since = 0; m_got = 0;
          end
        end
        M_FIN: m_phase = M_IDLE;
        M_JAM: if (bus.clear_fault) m_phase = M_IDLE;
        default: m_phase = M_IDLE;
      endcase
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    logic [11:0] act, exp;
    if (chk_en) begin
      act = {bus.eject, bus.busy, bus.done, bus.fault, bus.dispensed};
      exp = {m_phase == M_EJECT, m_phase != M_IDLE, m_phase == M_FIN,
             m_phase == M_JAM, 8'(m_disp)};
      check("cycle_outputs", 32'(act), 32'(exp));
    end
  end

  // Waveform tallies used by the directed scenarios.
  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_rise = 0, n_done = 0, fault_cyc = -1, cur_hi = 0, cur_lo = 0;
  int rise_q[$], hi_q[$], lo_q[$];
  bit mon_prev_ej = 0, mon_prev_fault = 0;

  always @(negedge clk) begin
    if (bus.eject === 1'b1) begin
      if (!mon_prev_ej) begin
        n_rise++; rise_q.push_back(cyc);
        if (n_rise > 1) lo_q.push_back(cur_lo);
      end
      cur_hi++; cur_lo = 0;
    end else begin
      if (mon_prev_ej) begin hi_q.push_back(cur_hi); cur_hi = 0; end
      cur_lo++;
    end
    if (bus.done === 1'b1) n_done++;
    if (bus.fault === 1'b1 && !mon_prev_fault) fault_cyc = cyc;
    mon_prev_ej    = (bus.eject === 1'b1);
    mon_prev_fault = (bus.fault === 1'b1);
  end

  task automatic clear_tally();
    n_rise = 0; n_done = 0; fault_cyc = -1; cur_hi = 0; cur_lo = 0;
    rise_q.delete(); hi_q.delete(); lo_q.delete();
  endtask

  // Coin sensor driver: 0 silent, 1 coin shortly after each eject fall,
  // 2 edge mid-pulse plus a bounce edge, 3 random toggling.
  int sense_mode = 0, resp_left = 0, delay = -1, hold = 0, pat = 0;
  bit armed = 0, drv_prev_ej = 0;

  always @(negedge clk) begin
    case (sense_mode)
      1: begin
        if (hold > 0) begin bus.coin_sense = 1'b1; hold--; end
        else bus.coin_sense = 1'b0;
        if (delay == 0) begin bus.coin_sense = 1'b1; hold = 1; delay = -1; end
        else if (delay > 0) delay--;
        if (drv_prev_ej && bus.eject !== 1'b1 && resp_left != 0) begin
          delay = 1;
          if (resp_left > 0) resp_left--;
        end
      end
      2: begin
        if (bus.eject === 1'b1 && !drv_prev_ej) armed = 1;
        if (pat != 0) begin
          bus.coin_sense = (pat == 2);
          pat = (pat == 3) ? 0 : pat + 1;
        end else if (armed && bus.eject === 1'b1 && drv_prev_ej) begin
          bus.coin_sense = 1'b1; pat = 1; armed = 0;
        end else bus.coin_sense = 1'b0;
      end
      3: if ($urandom_range(0, 2) == 0) bus.coin_sense = ~bus.coin_sense;
      default: bus.coin_sense = 1'b0;
    endcase
    drv_prev_ej = (bus.eject === 1'b1);
  end

  task automatic set_sense(input int mode, input int resp);
    sense_mode = mode; resp_left = resp; delay = -1; hold = 0; pat = 0; armed = 0;
  endtask

  task automatic do_start(input logic [7:0] a);
    bus.start = 1'b1; bus.amount = a;
    @(negedge clk);
    bus.start = 1'b0; bus.amount = 8'($urandom);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (bus.busy !== 1'b0 && n < budget) begin @(negedge clk); n++; end
    check(name, 32'(n < budget), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.amount = 8'd0; bus.clear_fault = 1'b0; bus.coin_sense = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'({bus.eject, bus.busy, bus.done, bus.fault, bus.dispensed}), 32'd0);
    chk_en = 1'b1;
    rst = 1'b0;
    @(negedge clk);

    // Three coins, each confirmed after its pulse.
    set_sense(1, -1); clear_tally();
    do_start(8'd3);
    wait_idle("amt3_finish", 200);
    check("amt3_pulses", 32'(n_rise), 32'd3);
    check("amt3_done", 32'(n_done), 32'd1);
    check("amt3_dispensed", 32'(bus.dispensed), 32'd3);
    check("amt3_model_disp", 32'(m_disp), 32'd3);
    foreach (hi_q[i]) check("amt3_pulse_len", 32'(hi_q[i]), 32'(PL));
    foreach (lo_q[i]) check("amt3_gap_min", 32'(lo_q[i] >= GL), 32'd1);

    // Zero amount: done on the following cycle, no eject.
    set_sense(0, 0); clear_tally();
    do_start(8'd0);
    check("amt0_done_next", 32'(bus.done), 32'd1);
    check("amt0_eject", 32'(bus.eject), 32'd0);
    @(negedge clk);
    check("amt0_idle", 32'({bus.busy, bus.done}), 32'd0);
    check("amt0_dispensed", 32'(bus.dispensed), 32'd0);
    check("amt0_pulses", 32'(n_rise), 32'd0);

    // Jam on the second coin, start ignored in FAULT, clear with simultaneous start.
    set_sense(1, 1); clear_tally();
    do_start(8'd2);
    begin
      int n = 0;
      while (bus.fault !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      check("jam_fault_seen", 32'(n < 100), 32'd1);
    end
    @(negedge clk);
    check("jam_rises", 32'(rise_q.size()), 32'd2);
    if (rise_q.size() >= 2) check("jam_fault_delay", 32'(fault_cyc - rise_q[1]), 32'(TO));
    check("jam_dispensed", 32'(bus.dispensed), 32'd1);
    check("jam_no_done", 32'(n_done), 32'd0);
    check("jam_model_disp", 32'(m_disp), 32'd1);
    bus.start = 1'b1; bus.amount = 8'd3;
    @(negedge clk);
    bus.start = 1'b0;
    check("jam_start_ignored", 32'({bus.fault, bus.busy, bus.eject}), 32'b110);
    bus.start = 1'b1; bus.clear_fault = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.clear_fault = 1'b0;
    check("jam_cleared", 32'({bus.fault, bus.busy}), 32'd0);
    @(negedge clk);
    check("jam_no_queued_start", 32'(bus.busy), 32'd0);

    // Coin during the pulse plus a bounce edge.
    set_sense(2, -1); clear_tally();
    do_start(8'd1);
    wait_idle("bounce_finish", 100);
    check("bounce_dispensed", 32'(bus.dispensed), 32'd1);
    check("bounce_done", 32'(n_done), 32'd1);
    check("bounce_pulses", 32'(n_rise), 32'd1);

    // Reset on the second eject cycle, then a normal single coin.
    set_sense(0, 0); clear_tally();
    do_start(8'd1);
    begin
      int n = 0;
      while (bus.eject !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      check("rst_eject_seen", 32'(n < 20), 32'd1);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_pulse", 32'({bus.eject, bus.busy, bus.done, bus.fault, bus.dispensed}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    set_sense(1, -1); clear_tally();
    do_start(8'd1);
    wait_idle("after_rst_finish", 100);
    check("after_rst_dispensed", 32'(bus.dispensed), 32'd1);
    check("after_rst_done", 32'(n_done), 32'd1);

    // A second start while busy is ignored.
    set_sense(1, -1); clear_tally();
    do_start(8'd2);
    repeat (3) @(negedge clk);
    do_start(8'd5);
    wait_idle("busy_start_finish", 200);
    check("busy_start_pulses", 32'(n_rise), 32'd2);
    check("busy_start_dispensed", 32'(bus.dispensed), 32'd2);
    check("busy_start_done", 32'(n_done), 32'd1);

    // Random traffic, including rare resets and random fault acknowledges.
    set_sense(3, -1);
    for (int i = 0; i < 1500; i++) begin
      rst             = ($urandom_range(0, 299) == 0);
      bus.start       = ($urandom_range(0, 5) == 0);
      bus.amount      = 8'($urandom_range(0, 3));
      bus.clear_fault = ($urandom_range(0, 7) == 0);
      @(negedge clk);
    end
    rst = 1'b0; bus.start = 1'b0; set_sense(0, 0);
    bus.clear_fault = 1'b1;
    @(negedge clk);
    bus.clear_fault = 1'b0;
    repeat (TO + PL) @(negedge clk);
    bus.clear_fault = 1'b1;
    @(negedge clk);
    bus.clear_fault = 1'b0;
    wait_idle("random_drain", 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
